// File: rtl/bp_cce_pkg.sv
// Shared CCE types and helpers used by the directory way-group reader.
package bp_cce_pkg;

    typedef enum logic [1:0] {
        e_IDLE  = 2'd0,
        e_READ  = 2'd1,
        e_DRAIN = 2'd2
    } bp_cce_dir_wg_reader_state_e;

    // Ceiling log2 that never returns zero, so one-entry fields keep a 1-bit width.
    function automatic int safe_clog2(input int x);
        if (x <= 1) begin
            return 1;
        end else begin
            return $clog2(x);
        end
    endfunction

endpackage

// File: rtl/bp_cce_dir_wg_reader_chk.sv
// Simulation checks for the directory way-group reader command interface.
module bp_cce_dir_wg_reader_chk #(
    parameter int num_way_groups_p = 16,
    parameter int lg_wg_p          = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               accept_i,
    input  logic [lg_wg_p-1:0] wg_id_i
);

    localparam logic [lg_wg_p:0] num_wg_lp = (lg_wg_p + 1)'(num_way_groups_p);

    // An accepted way-group id must name an existing way-group.
    wg_id_in_range: assert property (@(posedge clk_i) disable iff (reset_i)
        accept_i |-> ({1'b0, wg_id_i} < num_wg_lp));

endmodule

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear that saturates at max_val_p.
module bsg_counter_clear_up #(
    parameter int max_val_p = 1,
    parameter int width_p   = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
);

    localparam logic [width_p-1:0] max_lp = width_p'(max_val_p);

    logic [width_p-1:0] count_r;

    // Count register: reset and clear return to zero, up advances until max.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_r <= '0;
        end else if (clear_i) begin
            count_r <= '0;
        end else if (up_i && (count_r != max_lp)) begin
            count_r <= count_r + width_p'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count_o = count_r;

endmodule

// File: rtl/bp_cce_dir_wg_reader.sv
// Read sequencer in front of the CCE directory RAM: one command expands into
// rows_per_wg_p back-to-back row reads whose data is streamed downstream with
// the row index, requesting LCE and LRU way attached.
module bp_cce_dir_wg_reader
    import bp_cce_pkg::*;
#(
    parameter int num_way_groups_p = 16,
    parameter int rows_per_wg_p    = 2,
    parameter int row_width_p      = 128,
    parameter int num_lce_p        = 4,
    parameter int lce_assoc_p      = 8,
    localparam int lg_num_way_groups_lp = safe_clog2(num_way_groups_p),
    localparam int lg_rows_per_wg_lp    = safe_clog2(rows_per_wg_p),
    localparam int lg_num_lce_lp        = safe_clog2(num_lce_p),
    localparam int lg_lce_assoc_lp      = safe_clog2(lce_assoc_p),
    localparam int addr_width_lp        = safe_clog2(num_way_groups_p * rows_per_wg_p)
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            r_v_i,
    output logic                            r_ready_o,
    input  logic [lg_num_way_groups_lp-1:0] wg_id_i,
    input  logic [lg_num_lce_lp-1:0]        lce_i,
    input  logic [lg_lce_assoc_lp-1:0]      lru_way_i,
    output logic                            ram_v_o,
    output logic [addr_width_lp-1:0]        ram_addr_o,
    input  logic [row_width_p-1:0]          ram_data_i,
    output logic [row_width_p-1:0]          row_o,
    output logic                            row_v_o,
    output logic [lg_rows_per_wg_lp-1:0]    wg_row_o,
    output logic [lg_num_lce_lp-1:0]        lce_o,
    output logic [lg_lce_assoc_lp-1:0]      lru_way_o,
    output logic                            done_o
);

    localparam logic [lg_rows_per_wg_lp-1:0] last_row_lp = lg_rows_per_wg_lp'(rows_per_wg_p - 1);

    // Row address of a way-group row, computed wide enough that it never wraps.
    function automatic logic [addr_width_lp-1:0] row_addr(
        input logic [lg_num_way_groups_lp-1:0] wg,
        input logic [lg_rows_per_wg_lp-1:0]    row
    );
        logic [addr_width_lp-1:0] base_s;
        base_s = addr_width_lp'(wg) * addr_width_lp'(rows_per_wg_p);
        return base_s + addr_width_lp'(row);
    endfunction

    bp_cce_dir_wg_reader_state_e state_r, state_next_s;

    logic [lg_num_way_groups_lp-1:0] wg_id_r;
    logic [lg_num_lce_lp-1:0]        lce_r;
    logic [lg_lce_assoc_lp-1:0]      lru_way_r;
    logic                            ram_v_r;
    logic [lg_rows_per_wg_lp-1:0]    row_idx_r;
    logic [lg_rows_per_wg_lp-1:0]    issue_cnt_s;
    logic                            accept_s;
    logic                            last_issue_s;
    logic                            in_read_s;

    assign r_ready_o    = (state_r == e_IDLE) | (state_r == e_DRAIN);
    assign accept_s     = r_v_i & r_ready_o;
    assign in_read_s    = (state_r == e_READ);
    assign last_issue_s = (issue_cnt_s == last_row_lp);

    bsg_counter_clear_up #(
        .max_val_p (rows_per_wg_p - 1),
        .width_p   (lg_rows_per_wg_lp)
    ) issue_counter (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (accept_s),
        .up_i    (in_read_s),
        .count_o (issue_cnt_s)
    );

    bp_cce_dir_wg_reader_chk #(
        .num_way_groups_p (num_way_groups_p),
        .lg_wg_p          (lg_num_way_groups_lp)
    ) checker_inst (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .accept_i (accept_s),
        .wg_id_i  (wg_id_i)
    );

    // Next-state: accept starts a read burst, the last issue moves to drain.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            e_IDLE: begin
                if (accept_s) state_next_s = e_READ;
                else          state_next_s = e_IDLE;
            end
            e_READ: begin
                if (last_issue_s) state_next_s = e_DRAIN;
                else              state_next_s = e_READ;
            end
            e_DRAIN: begin
                if (accept_s) state_next_s = e_READ;
                else          state_next_s = e_IDLE;
            end
            default: state_next_s = e_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= e_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Command fields captured on accept and held until the next accept.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wg_id_r   <= '0;
            lce_r     <= '0;
            lru_way_r <= '0;
        end else if (accept_s) begin
            wg_id_r   <= wg_id_i;
            lce_r     <= lce_i;
            lru_way_r <= lru_way_i;
        end else begin
            wg_id_r   <= wg_id_r;
            lce_r     <= lce_r;
            lru_way_r <= lru_way_r;
        end
    end

    // Return tracking: remembers whether a row was issued last cycle and which.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ram_v_r   <= 1'b0;
            row_idx_r <= '0;
        end else begin
            ram_v_r   <= ram_v_o;
            row_idx_r <= issue_cnt_s;
        end
    end

    // RAM request: one row per READ cycle; address is zero when idle.
    always_comb begin
        ram_v_o    = 1'b0;
        ram_addr_o = '0;
        if (in_read_s && !reset_i) begin
            ram_v_o    = 1'b1;
            ram_addr_o = row_addr(wg_id_r, issue_cnt_s);
        end else begin
            ram_v_o    = 1'b0;
            ram_addr_o = '0;
        end
    end

    // Downstream row stream: RAM data passes straight through when valid.
    always_comb begin
        row_v_o  = 1'b0;
        row_o    = '0;
        wg_row_o = '0;
        if (ram_v_r && !reset_i) begin
            row_v_o  = 1'b1;
            row_o    = ram_data_i;
            wg_row_o = row_idx_r;
        end else begin
            row_v_o  = 1'b0;
            row_o    = '0;
            wg_row_o = '0;
        end
    end

    assign done_o    = row_v_o & (wg_row_o == last_row_lp);
    assign lce_o     = lce_r;
    assign lru_way_o = lru_way_r;

endmodule

// File: tb/tb_bp_cce_dir_wg_reader.sv
// Self-checking bench for bp_cce_dir_wg_reader: a 2-row instance checked
// against a transaction-level model every cycle, plus a 1-row instance.
module tb_bp_cce_dir_wg_reader;

    localparam int R2 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // 2-row instance
    logic         r_v2, ready2, ram_v2, row_v2, done2;
    logic [3:0]   wg2;
    logic [1:0]   lce2_in, lce2;
    logic [2:0]   lru2_in, lru2;
    logic [4:0]   addr2;
    logic [127:0] ram_data2, row2;
    logic [0:0]   wg_row2;

    // 1-row instance
    logic         r_v1, ready1, ram_v1, row_v1, done1;
    logic [3:0]   wg1;
    logic [1:0]   lce1_in, lce1;
    logic [2:0]   lru1_in, lru1;
    logic [3:0]   addr1;
    logic [127:0] ram_data1, row1;
    logic [0:0]   wg_row1;

    bp_cce_dir_wg_reader #(.num_way_groups_p(16), .rows_per_wg_p(2), .row_width_p(128),
                           .num_lce_p(4), .lce_assoc_p(8)) dut2 (
        .clk_i(clk), .reset_i(reset), .r_v_i(r_v2), .r_ready_o(ready2),
        .wg_id_i(wg2), .lce_i(lce2_in), .lru_way_i(lru2_in),
        .ram_v_o(ram_v2), .ram_addr_o(addr2), .ram_data_i(ram_data2),
        .row_o(row2), .row_v_o(row_v2), .wg_row_o(wg_row2),
        .lce_o(lce2), .lru_way_o(lru2), .done_o(done2));

    bp_cce_dir_wg_reader #(.num_way_groups_p(16), .rows_per_wg_p(1), .row_width_p(128),
                           .num_lce_p(4), .lce_assoc_p(8)) dut1 (
        .clk_i(clk), .reset_i(reset), .r_v_i(r_v1), .r_ready_o(ready1),
        .wg_id_i(wg1), .lce_i(lce1_in), .lru_way_i(lru1_in),
        .ram_v_o(ram_v1), .ram_addr_o(addr1), .ram_data_i(ram_data1),
        .row_o(row1), .row_v_o(row_v1), .wg_row_o(wg_row1),
        .lce_o(lce1), .lru_way_o(lru1), .done_o(done1));

    // Directory RAM contents as a pure function of the row address.
    function automatic logic [127:0] ram_row(input int a);
        return {32'(a) * 32'h9E3779B1, ~32'(a), 32'hC0DE0000 + 32'(a), 32'(a) ^ 32'h5A5A5A5A};
    endfunction

    // Synchronous 1-cycle RAMs; junk on the bus when no read was issued.
    always @(posedge clk) begin
        ram_data2 <= ram_v2 ? ram_row(int'(addr2)) : {4{32'hDEADBEEF}};
        ram_data1 <= ram_v1 ? ram_row(int'(addr1)) : {4{32'hDEADBEEF}};
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference model of the 2-row instance.
    typedef struct { int addr; int row; } iss_t;
    iss_t issue_q[$];
    bit   ret_v = 1'b0;
    iss_t ret_e;
    int   m_lce = 0, m_lru = 0;

    task automatic model_check();
        bit exp_ready, exp_ram_v, exp_row_v, exp_done;
        int exp_addr, exp_wg_row;
        logic [127:0] exp_row;
        exp_ready  = (issue_q.size() == 0);
        exp_ram_v  = !reset && (issue_q.size() > 0);
        exp_addr   = exp_ram_v ? issue_q[0].addr : 0;
        exp_row_v  = !reset && ret_v;
        exp_row    = exp_row_v ? ram_row(ret_e.addr) : 128'd0;
        exp_wg_row = exp_row_v ? ret_e.row : 0;
        exp_done   = exp_row_v && (ret_e.row == R2 - 1);
        chk("model.r_ready", 128'(ready2), 128'(exp_ready));
        chk("model.ram_v", 128'(ram_v2), 128'(exp_ram_v));
        chk("model.ram_addr", 128'(addr2), 128'(exp_addr));
        chk("model.row_v", 128'(row_v2), 128'(exp_row_v));
        chk("model.row", row2, exp_row);
        chk("model.wg_row", 128'(wg_row2), 128'(exp_wg_row));
        chk("model.done", 128'(done2), 128'(exp_done));
        chk("model.lce", 128'(lce2), 128'(m_lce));
        chk("model.lru_way", 128'(lru2), 128'(m_lru));
        if (reset) begin
            issue_q.delete();
            ret_v = 1'b0;
            m_lce = 0;
            m_lru = 0;
        end else begin
            ret_v = exp_ram_v;
            if (exp_ram_v) ret_e = issue_q.pop_front();
            if (r_v2 && exp_ready) begin
                for (int r = 0; r < R2; r++) issue_q.push_back('{int'(wg2) * R2 + r, r});
                m_lce = int'(lce2_in);
                m_lru = int'(lru2_in);
            end
        end
    endtask

    // Observations captured mid-cycle for the directed checks.
    logic         o_ready2, o_ram_v2, o_row_v2, o_done2;
    logic [4:0]   o_addr2;
    logic [0:0]   o_wg_row2;
    logic [1:0]   o_lce2;
    logic [2:0]   o_lru2;
    logic         o_ready1, o_ram_v1, o_row_v1, o_done1;
    logic [3:0]   o_addr1;
    logic [0:0]   o_wg_row1;
    logic [127:0] o_row2, o_row1;

    // One clock cycle: inputs are already driven; sample #2 after negedge.
    task automatic tick();
        #2;
        model_check();
        o_ready2 = ready2; o_ram_v2 = ram_v2; o_row_v2 = row_v2; o_done2 = done2;
        o_addr2 = addr2; o_wg_row2 = wg_row2; o_lce2 = lce2; o_lru2 = lru2; o_row2 = row2;
        o_ready1 = ready1; o_ram_v1 = ram_v1; o_row_v1 = row_v1; o_done1 = done1;
        o_addr1 = addr1; o_wg_row1 = wg_row1; o_row1 = row1;
        @(negedge clk);
    endtask

    typedef struct { int wg; int lce; int lru; int a0; int a1; } vec_t;
    vec_t tbl[4];

    initial begin
        tbl[0] = '{5, 3, 6, 10, 11};
        tbl[1] = '{0, 0, 0, 0, 1};
        tbl[2] = '{15, 1, 7, 30, 31};
        tbl[3] = '{8, 2, 3, 16, 17};

        reset = 1'b1;
        r_v2 = 1'b0; wg2 = 4'd0; lce2_in = 2'd0; lru2_in = 3'd0;
        r_v1 = 1'b0; wg1 = 4'd0; lce1_in = 2'd0; lru1_in = 3'd0;
        @(negedge clk);

        // Reset held for three cycles, then idle.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset.r_ready", 128'(o_ready2), 128'd1);
            chk("reset.ram_v", 128'(o_ram_v2), 128'd0);
            chk("reset.done", 128'(o_done2), 128'd0);
        end
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("idle.r_ready", 128'(o_ready2), 128'd1);
            chk("idle.row_v", 128'(o_row_v2), 128'd0);
        end

        // Table of single transactions on the 2-row instance.
        for (int i = 0; i < 4; i++) begin
            r_v2 = 1'b1; wg2 = 4'(tbl[i].wg); lce2_in = 2'(tbl[i].lce); lru2_in = 3'(tbl[i].lru);
            tick();
            r_v2 = 1'b0;
            tick();
            chk("tbl.c1.ram_v", 128'(o_ram_v2), 128'd1);
            chk("tbl.c1.addr", 128'(o_addr2), 128'(tbl[i].a0));
            chk("tbl.c1.r_ready", 128'(o_ready2), 128'd0);
            tick();
            chk("tbl.c2.addr", 128'(o_addr2), 128'(tbl[i].a1));
            chk("tbl.c2.row_v", 128'(o_row_v2), 128'd1);
            chk("tbl.c2.wg_row", 128'(o_wg_row2), 128'd0);
            chk("tbl.c2.row", o_row2, ram_row(tbl[i].a0));
            chk("tbl.c2.done", 128'(o_done2), 128'd0);
            tick();
            chk("tbl.c3.ram_v", 128'(o_ram_v2), 128'd0);
            chk("tbl.c3.wg_row", 128'(o_wg_row2), 128'd1);
            chk("tbl.c3.row", o_row2, ram_row(tbl[i].a1));
            chk("tbl.c3.done", 128'(o_done2), 128'd1);
            chk("tbl.c3.lce", 128'(o_lce2), 128'(tbl[i].lce));
            chk("tbl.c3.lru_way", 128'(o_lru2), 128'(tbl[i].lru));
            tick();
            chk("tbl.c4.done", 128'(o_done2), 128'd0);
            chk("tbl.c4.r_ready", 128'(o_ready2), 128'd1);
        end

        // Back-to-back: wg 5 then wg 15 with r_v held.
        r_v2 = 1'b1; wg2 = 4'd5; lce2_in = 2'd1; lru2_in = 3'd2;
        tick();
        wg2 = 4'd15; lce2_in = 2'd2; lru2_in = 3'd5;
        tick();
        chk("b2b.c1.addr", 128'(o_addr2), 128'd10);
        tick();
        chk("b2b.c2.addr", 128'(o_addr2), 128'd11);
        tick();
        r_v2 = 1'b0;
        chk("b2b.c3.r_ready", 128'(o_ready2), 128'd1);
        chk("b2b.c3.done", 128'(o_done2), 128'd1);
        chk("b2b.c3.lce_old", 128'(o_lce2), 128'd1);
        tick();
        chk("b2b.c4.addr", 128'(o_addr2), 128'd30);
        chk("b2b.c4.row_v_gap", 128'(o_row_v2), 128'd0);
        tick();
        chk("b2b.c5.addr", 128'(o_addr2), 128'd31);
        chk("b2b.c5.row_v", 128'(o_row_v2), 128'd1);
        tick();
        chk("b2b.c6.done", 128'(o_done2), 128'd1);
        chk("b2b.c6.lce_new", 128'(o_lce2), 128'd2);
        chk("b2b.c6.lru_new", 128'(o_lru2), 128'd5);
        tick();

        // Single-row instance: wg 7, then wg 15 from the drain cycle.
        r_v1 = 1'b1; wg1 = 4'd7; lce1_in = 2'd2; lru1_in = 3'd4;
        tick();
        r_v1 = 1'b0;
        tick();
        chk("r1.c1.ram_v", 128'(o_ram_v1), 128'd1);
        chk("r1.c1.addr", 128'(o_addr1), 128'd7);
        chk("r1.c1.row_v", 128'(o_row_v1), 128'd0);
        r_v1 = 1'b1; wg1 = 4'd15;
        tick();
        r_v1 = 1'b0;
        chk("r1.c2.row_v", 128'(o_row_v1), 128'd1);
        chk("r1.c2.done", 128'(o_done1), 128'd1);
        chk("r1.c2.wg_row", 128'(o_wg_row1), 128'd0);
        chk("r1.c2.row", o_row1, ram_row(7));
        chk("r1.c2.r_ready", 128'(o_ready1), 128'd1);
        tick();
        chk("r1.c3.addr", 128'(o_addr1), 128'd15);
        tick();
        chk("r1.c4.row", o_row1, ram_row(15));
        chk("r1.c4.done", 128'(o_done1), 128'd1);
        tick();
        chk("r1.c5.row_v", 128'(o_row_v1), 128'd0);

        // Reset in the cycle after the first read of a 2-row transaction.
        r_v2 = 1'b1; wg2 = 4'd3; lce2_in = 2'd3; lru2_in = 3'd1;
        tick();
        r_v2 = 1'b0;
        tick();
        chk("rst.c1.addr", 128'(o_addr2), 128'd6);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst.after.r_ready", 128'(o_ready2), 128'd1);
            chk("rst.after.row_v", 128'(o_row_v2), 128'd0);
            chk("rst.after.done", 128'(o_done2), 128'd0);
            chk("rst.after.lce", 128'(o_lce2), 128'd0);
        end

        // Random traffic with occasional resets, checked by the model.
        for (int i = 0; i < 600; i++) begin
            reset   = ($urandom_range(0, 63) == 0);
            r_v2    = 1'($urandom_range(0, 1));
            wg2     = 4'($urandom_range(0, 15));
            lce2_in = 2'($urandom_range(0, 3));
            lru2_in = 3'($urandom_range(0, 7));
            tick();
        end
        reset = 1'b0; r_v2 = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
